// File: rtl/tdm_demux2_pkg.sv
// rtl/tdm_demux2_pkg.sv - shared state encoding and channel tags for the 2:1 TDM mux/demux family
package tdm_demux2_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        FULL   = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/tdm_demux2.sv
// rtl/tdm_demux2.sv - two-channel TDM demultiplexer reassembling A-then-B word pairs
module tdm_demux2
    import tdm_demux2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_seq,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pair_count
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_set;
    logic               in_xfer;
    logic               out_xfer;

    // Handshake outputs depend only on the state register, never on out_ready.
    assign din_ready  = (state_q != FULL);
    assign out_valid  = (state_q == FULL);
    assign a_out      = a_q;
    assign b_out      = b_q;
    assign err_seq    = err_q;
    assign pair_count = cnt_q;

    assign in_xfer  = din_valid & din_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (in_xfer) begin
                    if (sel == SEL_A) begin
                        a_d     = din;
                        state_d = WAIT_B;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            WAIT_B: begin
                if (in_xfer) begin
                    if (sel == SEL_B) begin
                        b_d     = din;
                        state_d = FULL;
                    end else begin
                        // A repeated: keep the newest A so the next B pairs with it.
                        a_d     = din;
                        err_set = 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = WAIT_A;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = WAIT_A;
        endcase
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// tb/tb_tdm_demux2.sv - scoreboard bench for tdm_demux2 with a pair-level reference model
module tb_tdm_demux2;

    localparam int WIDTH = 8;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             sel = 1'b0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             err_seq;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] pair_count;

    int checks = 0;
    int errors = 0;

    tdm_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .din_valid(din_valid),
        .din_ready(din_ready), .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
        .out_ready(out_ready), .err_seq(err_seq), .err_clr(err_clr), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a pending A word, a pair-outstanding flag and a queue of expected pairs.
    logic [WIDTH-1:0]     m_a;
    bit                   m_have_a;
    bit                   m_full;
    bit                   m_err;
    bit                   m_e;
    logic [CNT_W-1:0]     m_cnt;
    logic [2*WIDTH-1:0]   exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = '0; m_have_a = 0; m_full = 0; m_err = 0; m_cnt = '0;
            exp_q.delete();
        end else begin
            m_e = 0;
            if (m_full) begin
                if (out_ready) begin
                    m_full = 0;
                    m_cnt  = m_cnt + 1'b1;
                end
            end else if (din_valid) begin
                if (sel == 1'b0) begin
                    if (m_have_a) m_e = 1;
                    m_a = din;
                    m_have_a = 1;
                end else if (m_have_a) begin
                    exp_q.push_back({m_a, din});
                    m_have_a = 0;
                    m_full = 1;
                end else begin
                    m_e = 1;
                end
            end
            if (m_e) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    // Monitor: compares every cycle on the falling edge and pops on each output transfer.
    always @(negedge clk) begin
        chk("out_valid", out_valid, m_full);
        chk("err_seq", err_seq, m_err);
        chk("pair_count", pair_count, m_cnt);
        if (rst_n) chk("din_ready", din_ready, !m_full);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: out_valid=1 with no expected pair at %0t", $time);
            end else begin
                chk("a_out", a_out, exp_q[0][2*WIDTH-1:WIDTH]);
                chk("b_out", b_out, exp_q[0][WIDTH-1:0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_valid = 0; out_ready = 0; err_clr = 0; sel = 0;
    endtask

    task automatic send(input logic s, input logic [WIDTH-1:0] d);
        din_valid = 1; sel = s; din = d;
        step();
        din_valid = 0;
    endtask

    task automatic drive_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        send(1'b0, a);
        send(1'b1, b);
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic do_reset();
        #1 rst_n = 0;
        step();
        rst_n = 1;
        idle();
    endtask

    logic [WIDTH-1:0] hold_a;

    initial begin
        // Reset with random inputs applied
        for (int i = 0; i < 5; i++) begin
            din = WIDTH'($urandom); sel = 1'($urandom); din_valid = 1'($urandom);
            out_ready = 1'($urandom); err_clr = 1'($urandom);
            step();
            chk("rst_a_out", a_out, 0);
            chk("rst_b_out", b_out, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_pair_count", pair_count, 0);
            chk("rst_err_seq", err_seq, 0);
        end
        rst_n = 1;
        idle();
        step();
        chk("post_rst_din_ready", din_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Nominal pair
        send(1'b0, 8'h3C);
        send(1'b1, 8'hA5);
        chk("nom_out_valid", out_valid, 1);
        chk("nom_a_out", a_out, 8'h3C);
        chk("nom_b_out", b_out, 8'hA5);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("nom_valid_one_cycle", out_valid, 0);
        chk("nom_pair_count", pair_count, 1);

        // Backpressure
        send(1'b0, 8'h5A);
        send(1'b1, 8'hC3);
        for (int i = 0; i < 5; i++) begin
            din_valid = 1; sel = 1'($urandom); din = WIDTH'($urandom);
            step();
            chk("bp_din_ready", din_ready, 0);
            chk("bp_a_stable", a_out, 8'h5A);
            chk("bp_b_stable", b_out, 8'hC3);
        end
        din_valid = 1; sel = 0; din = 8'h77; out_ready = 1;
        step();
        out_ready = 0;
        chk("bp_pair_count", pair_count, 2);
        chk("bp_din_ready_after", din_ready, 1);
        step();
        din_valid = 0;
        chk("bp_next_a", a_out, 8'h77);
        send(1'b1, 8'h88);
        out_ready = 1;
        step();
        idle();

        // Sequence errors
        send(1'b1, 8'h11);
        chk("seq_err_set", err_seq, 1);
        chk("seq_drop_out_valid", out_valid, 0);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        send(1'b1, 8'h44);
        chk("seq_a_out", a_out, 8'h33);
        chk("seq_b_out", b_out, 8'h44);
        out_ready = 1;
        step();
        out_ready = 0;
        err_clr = 1;
        send(1'b1, 8'h55);
        chk("seq_set_wins", err_seq, 1);
        step();
        err_clr = 0;
        chk("seq_cleared", err_seq, 0);

        // Reset mid-operation in WAIT_B and in FULL
        send(1'b0, 8'h99);
        rst_n = 0;
        #1;
        chk("midrst_b_count", pair_count, 0);
        chk("midrst_b_valid", out_valid, 0);
        step();
        rst_n = 1;
        step();
        send(1'b0, 8'h12);
        send(1'b1, 8'h34);
        chk("midrst_full_valid_pre", out_valid, 1);
        rst_n = 0;
        #1;
        chk("midrst_full_valid", out_valid, 0);
        chk("midrst_full_a", a_out, 0);
        step();
        rst_n = 1;
        step();

        // Counter wrap
        for (int i = 0; i < (1 << CNT_W) - 1; i++)
            drive_pair(WIDTH'($urandom), WIDTH'($urandom));
        chk("wrap_pre", pair_count, (1 << CNT_W) - 1);
        drive_pair(8'hF0, 8'h0F);
        chk("wrap_zero", pair_count, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            sel       = 1'($urandom);
            din       = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
